// File: rtl/sram_req_arbiter.sv
// Two-master SRAM-like arbiter: instruction and data sides share one downstream port.
// Data has fixed priority; an in-order ID FIFO routes responses back and drops cancelled fetches.
module sram_req_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    input  logic        inst_cancel,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOCK_I,
        LOCK_D
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] id_q, id_d;
    logic [DEPTH-1:0] disc_q, disc_d;

    logic             sel_data;
    logic             owner_req;
    logic             not_full;
    logic             accept;
    logic             pop;
    logic             head_id;
    logic             head_disc;
    logic [DEPTH-1:0] live;

    // Owner follows priority only while idle; a lock pins it until the stalled request is taken.
    always_comb begin
        sel_data = data_req;
        unique case (state_q)
            IDLE:    sel_data = data_req;
            LOCK_I:  sel_data = 1'b0;
            LOCK_D:  sel_data = 1'b1;
            default: sel_data = data_req;
        endcase
    end

    assign owner_req = sel_data ? data_req : inst_req;
    assign not_full  = (count_q != FULL);

    assign mem_req   = owner_req & not_full;
    assign mem_wr    = sel_data ? data_wr    : inst_wr;
    assign mem_size  = sel_data ? data_size  : inst_size;
    assign mem_addr  = sel_data ? data_addr  : inst_addr;
    assign mem_wstrb = sel_data ? data_wstrb : inst_wstrb;
    assign mem_wdata = sel_data ? data_wdata : inst_wdata;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & ~sel_data;
    assign data_addr_ok = accept & sel_data;

    assign pop       = mem_data_ok & (count_q != '0);
    assign head_id   = id_q[rptr_q];
    assign head_disc = disc_q[rptr_q];

    assign inst_data_ok = pop & ~head_id & ~head_disc;
    assign data_data_ok = pop &  head_id & ~head_disc;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Slot is live if it sits inside [rptr, rptr+count) or is being written this cycle.
    always_comb begin
        live = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            live[i] = ({1'b0, PW'(PW'(i) - rptr_q)} < count_q)
                    | (accept & (PW'(i) == wptr_q));
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req && !mem_addr_ok) begin
                    state_d = sel_data ? LOCK_D : LOCK_I;
                end
            end
            LOCK_I, LOCK_D: begin
                if (accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        id_d    = id_q;
        disc_d  = disc_q;

        if (accept) begin
            id_d[wptr_q]   = sel_data;
            disc_d[wptr_q] = 1'b0;
            wptr_d         = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end

        unique case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Cancel applies after the push so a fetch accepted in the flush cycle is dropped too.
        if (inst_cancel) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (live[i] && !id_d[i]) begin
                    disc_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            id_q    <= '0;
            disc_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            id_q    <= id_d;
            disc_q  <= disc_d;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: expected response owners queued at acceptance,
// popped and compared when mem_data_ok is driven.
module tb_sram_req_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic [3:0]  inst_wstrb;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        inst_cancel;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int unsigned n_vec;
    int unsigned n_err;

    typedef struct packed {
        logic id;
        logic disc;
    } ent_t;

    ent_t exp_q[$];

    sram_req_arbiter #(.DEPTH(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wstrb   (inst_wstrb),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .inst_cancel  (inst_cancel),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = '0;
        inst_wstrb = '0; inst_wdata = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0;
        data_wstrb = '0; data_wdata = '0;
        inst_cancel = 1'b0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    endtask

    task automatic drive_inst(input logic [31:0] addr);
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = addr;
        inst_wstrb = 4'h0; inst_wdata = addr ^ 32'h5A5A_0000;
    endtask

    task automatic drive_data(input logic [31:0] addr);
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = addr;
        data_wstrb = 4'h3; data_wdata = ~addr;
    endtask

    task automatic mark_cancel();
        foreach (exp_q[k]) begin
            if (!exp_q[k].id) exp_q[k].disc = 1'b1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_req"},  mem_req, 0);
        check({tag, "_i_aok"},    inst_addr_ok, 0);
        check({tag, "_d_aok"},    data_addr_ok, 0);
        check({tag, "_i_dok"},    inst_data_ok, 0);
        check({tag, "_d_dok"},    data_data_ok, 0);
    endtask

    // One-cycle accepted request from the chosen side; fields and addr_ok routing are checked.
    task automatic accept(input logic side, input logic [31:0] addr, input logic cancel);
        if (side) drive_data(addr); else drive_inst(addr);
        mem_addr_ok = 1'b1;
        inst_cancel = cancel;
        #1;
        check("acc_mem_req", mem_req, 1);
        check("acc_mem_addr", mem_addr, addr);
        check("acc_mem_wr", mem_wr, side);
        check("acc_mem_size", mem_size, side ? 2'd1 : 2'd2);
        check("acc_mem_wstrb", mem_wstrb, side ? 4'h3 : 4'h0);
        check("acc_mem_wdata", mem_wdata, side ? ~addr : (addr ^ 32'h5A5A_0000));
        check("acc_i_aok", inst_addr_ok, !side);
        check("acc_d_aok", data_addr_ok, side);
        exp_q.push_back('{id: side, disc: 1'b0});
        if (cancel) mark_cancel();
        step();
        clear_inputs();
    endtask

    // Compare the current response cycle against the scoreboard head.
    task automatic check_pop(input logic [31:0] v);
        ent_t e;
        if (exp_q.size() == 0) begin
            check("stray_i_dok", inst_data_ok, 0);
            check("stray_d_dok", data_data_ok, 0);
        end else begin
            e = exp_q.pop_front();
            check("rsp_i_dok", inst_data_ok, (!e.id && !e.disc));
            check("rsp_d_dok", data_data_ok, (e.id && !e.disc));
            if (!e.disc) begin
                if (e.id) check("rsp_d_rdata", data_rdata, v);
                else      check("rsp_i_rdata", inst_rdata, v);
            end
        end
    endtask

    task automatic respond(input logic [31:0] v);
        mem_data_ok = 1'b1;
        mem_rdata   = v;
        #1;
        check_pop(v);
        step();
        mem_data_ok = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_inputs();
        resetn = 1'b0;
        repeat (3) step();
        check_idle_outputs("rst_in");
        resetn = 1'b1;
        step();
        check_idle_outputs("rst_out");

        // Both sides request together: data wins, inst follows next cycle.
        drive_inst(32'h1C00_0000);
        drive_data(32'h0000_1000);
        mem_addr_ok = 1'b1;
        #1;
        check("pri_mem_addr", mem_addr, 32'h0000_1000);
        check("pri_d_aok", data_addr_ok, 1);
        check("pri_i_aok", inst_addr_ok, 0);
        exp_q.push_back('{id: 1'b1, disc: 1'b0});
        step();
        data_req = 1'b0;
        #1;
        check("pri2_mem_addr", mem_addr, 32'h1C00_0000);
        check("pri2_i_aok", inst_addr_ok, 1);
        check("pri2_d_aok", data_addr_ok, 0);
        exp_q.push_back('{id: 1'b0, disc: 1'b0});
        step();
        clear_inputs();
        respond(32'hAAAA_5555);
        respond(32'h1234_5678);

        // Stalled inst request locks the port even when data arrives.
        drive_inst(32'h1C00_0040);
        mem_addr_ok = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) drive_data(32'h0000_2000);
            #1;
            check("lock_mem_addr", mem_addr, 32'h1C00_0040);
            check("lock_mem_req", mem_req, 1);
            check("lock_d_aok", data_addr_ok, 0);
            step();
        end
        mem_addr_ok = 1'b1;
        #1;
        check("lock_acc_addr", mem_addr, 32'h1C00_0040);
        check("lock_acc_i_aok", inst_addr_ok, 1);
        check("lock_acc_d_aok", data_addr_ok, 0);
        exp_q.push_back('{id: 1'b0, disc: 1'b0});
        step();
        inst_req = 1'b0;
        #1;
        check("unlock_addr", mem_addr, 32'h0000_2000);
        check("unlock_d_aok", data_addr_ok, 1);
        exp_q.push_back('{id: 1'b1, disc: 1'b0});
        step();
        clear_inputs();
        respond(32'h0BAD_F00D);
        respond(32'hCAFE_0001);

        // Fill to DEPTH; the fifth request waits out the pop cycle, then goes.
        accept(1'b1, 32'h0000_3000, 1'b0);
        accept(1'b0, 32'h1C00_0100, 1'b0);
        accept(1'b1, 32'h0000_3004, 1'b0);
        accept(1'b0, 32'h1C00_0104, 1'b0);
        drive_inst(32'h1C00_0108);
        mem_addr_ok = 1'b1;
        #1;
        check("full_mem_req", mem_req, 0);
        check("full_i_aok", inst_addr_ok, 0);
        step();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h5555_0001;
        #1;
        check_pop(32'h5555_0001);
        check("full_pop_mem_req", mem_req, 0);
        check("full_pop_i_aok", inst_addr_ok, 0);
        step();
        mem_data_ok = 1'b0;
        #1;
        check("freed_mem_req", mem_req, 1);
        check("freed_i_aok", inst_addr_ok, 1);
        check("freed_addr", mem_addr, 32'h1C00_0108);
        exp_q.push_back('{id: 1'b0, disc: 1'b0});
        step();
        clear_inputs();
        for (int k = 0; k < 4; k++) respond(32'h6000_0000 + 32'(k));

        // Cancel discards outstanding inst entries, including one pushed that cycle.
        accept(1'b0, 32'h1C00_0200, 1'b0);
        accept(1'b0, 32'h1C00_0204, 1'b1);
        accept(1'b1, 32'h0000_4000, 1'b0);
        respond(32'h7000_0000);
        respond(32'h7000_0001);
        respond(32'h7000_0002);
        respond(32'h7000_0003);

        // Reset mid-flight drops outstanding entries.
        accept(1'b1, 32'h0000_5000, 1'b0);
        accept(1'b0, 32'h1C00_0300, 1'b0);
        accept(1'b1, 32'h0000_5004, 1'b0);
        resetn = 1'b0;
        step();
        check_idle_outputs("mrst_in");
        resetn = 1'b1;
        exp_q.delete();
        step();
        check_idle_outputs("mrst_out");
        respond(32'h8000_0000);
        for (int k = 0; k < 4; k++) accept(k[0], 32'h0000_6000 + 32'(k * 4), 1'b0);
        drive_data(32'h0000_6100);
        mem_addr_ok = 1'b1;
        #1;
        check("mrst_full_mem_req", mem_req, 0);
        check("mrst_full_d_aok", data_addr_ok, 0);
        step();
        clear_inputs();
        for (int k = 0; k < 4; k++) respond(32'h9000_0000 + 32'(k));

        // Random mix of accepts, cancels and responses.
        for (int it = 0; it < 40; it++) begin
            if (exp_q.size() < 4 && ($urandom_range(0, 1) == 0 || exp_q.size() == 0)) begin
                logic s;
                s = 1'($urandom_range(0, 1));
                accept(s, $urandom & 32'hFFFF_FFFC, (!s && $urandom_range(0, 3) == 0));
            end else begin
                respond($urandom);
            end
        end
        while (exp_q.size() > 0) respond($urandom);
        respond(32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the maximum number of outstanding accepted-but-unanswered requests (power of two, 2..8).
REQ-002 SHALL have ports clk input 1, the single clock; resetn input 1, synchronous active-low reset.
REQ-003 SHALL have inst_req input 1, inst_wr input 1, inst_size input 2, inst_addr input 32, inst_wstrb input 4, inst_wdata input 32: the instruction-side SRAM-like request.
REQ-004 SHALL have inst_addr_ok output 1, inst_data_ok output 1, inst_rdata output 32: the instruction-side responses.
REQ-005 SHALL have data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata (inputs, same widths as REQ-003), plus data_addr_ok output 1, data_data_ok output 1, data_rdata output 32: the data-side (MEM stage) request and responses.
REQ-006 SHALL have inst_cancel input 1, a one-cycle pulse from the pipeline flush that discards pending instruction responses.
REQ-007 SHALL have mem_req output 1, mem_wr output 1, mem_size output 2, mem_addr output 32, mem_wstrb output 4, mem_wdata output 32, mem_addr_ok input 1, mem_data_ok input 1, mem_rdata input 32: the shared downstream SRAM-like port.

Function
REQ-008 SHALL contain a lock FSM with states IDLE, LOCK_I and LOCK_D, where the owner is selected combinationally in IDLE and held by the register in LOCK_x.
REQ-009 In IDLE, the owner SHALL be data if data_req=1, else inst if inst_req=1 (fixed priority to data).
REQ-010 mem_req SHALL equal (owner's req) & (count<DEPTH); all mem_* request fields SHALL be muxed from the owner.
REQ-011 IDLE->LOCK_x SHALL occur when mem_req=1 and mem_addr_ok=0; LOCK_x->IDLE SHALL occur when mem_addr_ok=1 while mem_req=1. In IDLE, a same-cycle mem_addr_ok accepts without locking.
REQ-012 In LOCK_x, the owner SHALL stay x even if the other side raises req, so downstream request fields stay stable until accepted.
REQ-013 Acceptance SHALL be mem_req & mem_addr_ok; only the owner's addr_ok SHALL be 1 and the other side's SHALL be 0. addr_ok to either side SHALL be 0 when count==DEPTH.
REQ-014 On acceptance, entry {id, discard=0} SHALL be pushed into an in-order FIFO of DEPTH entries with wrap-around pointers, where id is 0 for inst and 1 for data.
REQ-015 On mem_data_ok with count>0, the head SHALL be popped. If its discard=0, <id>_data_ok=1 for exactly that cycle. If its discard=1, neither data_ok SHALL assert.
REQ-016 inst_rdata and data_rdata SHALL both equal mem_rdata combinationally; only data_ok qualifies them.
REQ-017 mem_data_ok with count==0 SHALL be ignored: no data_ok, no pointer or count change.
REQ-018 A simultaneous push and pop SHALL both take effect with count unchanged.
REQ-019 When count==DEPTH, new grants SHALL be blocked even if a pop occurs in the same cycle; the block is re-evaluated next cycle.
REQ-020 An inst_cancel pulse SHALL set discard=1 on every valid FIFO entry with id=0, including an inst entry pushed in the same cycle. Data entries SHALL be unaffected.
REQ-021 inst_cancel SHALL NOT abort a pending LOCK_I handshake; the accepted request is pushed and then discarded only if a later cancel marks it.
REQ-022 Responses SHALL be returned strictly in acceptance order; there is no reordering between inst and data.
REQ-023 Latency: addr_ok is combinational from mem_addr_ok (0 extra cycles), and data_ok is combinational from mem_data_ok (0 extra cycles).

Reset
REQ-024 While resetn=0 at a clk edge, the block SHALL force FSM=IDLE, FIFO pointers=0, count=0 and all discard bits=0.
REQ-025 During and immediately after reset, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok SHALL be 0 (given requests low). Reset mid-transaction SHALL drop all outstanding entries.

Verification
REQ-026 inst_req and data_req both 1, addr 0x1C000000/0x00001000, mem_addr_ok=1 -> mem_addr=0x00001000, data_addr_ok=1, inst_addr_ok=0; inst is granted the next cycle.
REQ-027 inst_req=1, mem_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays the inst address, FSM=LOCK_I; inst is accepted when addr_ok=1 and data is granted afterwards.
REQ-028 Accept data then inst, then mem_data_ok twice with rdata 0xAAAA5555 and 0x12345678 -> data_data_ok with 0xAAAA5555, then inst_data_ok with 0x12345678.
REQ-029 DEPTH=4 requests accepted with no data_ok -> 5th request sees mem_req=0; one mem_data_ok frees a slot, and the 5th request is accepted on the following cycle.
REQ-030 Two inst entries outstanding, inst_cancel pulse, then a data request accepted and 3 mem_data_ok pulses -> no inst_data_ok, a single data_data_ok, count returns to 0.
REQ-031 resetn=0 with 3 entries outstanding -> after release count=0, mem_req=0 with no request, and a stray mem_data_ok produces no data_ok.
